// File: rtl/sipo_rx_if.sv
// Serial-in / parallel-out link bundle: serial input side plus the valid/ready word output
// and the status pulses of the sipo_rx deserializer.
interface sipo_rx_if #(
    parameter int WIDTH = 4
);
    logic             ser_valid_i;
    logic             ser_data_i;
    logic             ready_i;
    logic [WIDTH-1:0] data_o;
    logic             valid_o;
    logic             busy_o;
    logic             frame_err_o;
    logic             overrun_o;
    logic             parity_err_o;

    modport slave (
        input  ser_valid_i, ser_data_i, ready_i,
        output data_o, valid_o, busy_o, frame_err_o, overrun_o, parity_err_o
    );

    modport master (
        output ser_valid_i, ser_data_i, ready_i,
        input  data_o, valid_o, busy_o, frame_err_o, overrun_o, parity_err_o
    );
endinterface

// File: rtl/sipo_rx.sv
// Serial-to-parallel receiver for the piso link: assembles WIDTH-bit words, flags truncation/overrun.
// Optional even-parity trailer bit enabled by defining SIPO_RX_PARITY_CHECK_EN.
//
// state | meaning
// IDLE  | waiting for bit 0 of a frame
// SHIFT | frame in progress, collecting bits 1..L-1
module sipo_rx #(
    parameter int WIDTH     = 4,
    parameter bit MSB_FIRST = 1'b1
) (
    input  logic      clk_i,
    input  logic      rst_n_i,
    input  logic      clear_i,
    sipo_rx_if.slave  bus
);
`ifdef SIPO_RX_PARITY_CHECK_EN
    localparam int L = WIDTH + 1;
`else
    localparam int L = WIDTH;
`endif
    localparam int CW = $clog2(L + 1);

    typedef enum logic {IDLE = 1'b0, SHIFT = 1'b1} state_t;

    state_t           state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] shreg_q, shreg_d;
    logic [WIDTH-1:0] data_q, data_d;
    logic             valid_q, valid_d;
    logic             frame_err_q, frame_err_d;
    logic             overrun_q, overrun_d;
    logic [WIDTH-1:0] base, shifted, word;
    logic             last_bit, word_done;
`ifdef SIPO_RX_PARITY_CHECK_EN
    logic             parity_err_q, parity_err_d;
`endif

    // Bit 0 always starts from a clean register so stale bits never leak into a word.
    always_comb begin
        base    = (state_q == SHIFT) ? shreg_q : '0;
        shifted = MSB_FIRST ? {base[WIDTH-2:0], bus.ser_data_i}
                            : {bus.ser_data_i, base[WIDTH-1:1]};
`ifdef SIPO_RX_PARITY_CHECK_EN
        word    = shreg_q;
`else
        word    = shifted;
`endif
    end

    assign last_bit = (state_q == SHIFT) && (cnt_q == CW'(L - 1));

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        shreg_d     = shreg_q;
        data_d      = data_q;
        valid_d     = valid_q;
        frame_err_d = 1'b0;
        overrun_d   = 1'b0;
        word_done   = 1'b0;
`ifdef SIPO_RX_PARITY_CHECK_EN
        parity_err_d = 1'b0;
`endif
        if (clear_i) begin
            state_d = IDLE;
            cnt_d   = '0;
            shreg_d = '0;
            valid_d = 1'b0;
        end else begin
            if (valid_q && bus.ready_i) valid_d = 1'b0;
            case (state_q)
                IDLE: begin
                    if (bus.ser_valid_i) begin
                        shreg_d = shifted;
                        cnt_d   = CW'(1);
                        state_d = SHIFT;
                    end
                end
                SHIFT: begin
                    if (bus.ser_valid_i) begin
                        if (last_bit) begin
                            state_d = IDLE;
                            cnt_d   = '0;
                            shreg_d = '0;
`ifdef SIPO_RX_PARITY_CHECK_EN
                            if (^{shreg_q, bus.ser_data_i}) parity_err_d = 1'b1;
                            else                            word_done    = 1'b1;
`else
                            word_done = 1'b1;
`endif
                        end else begin
                            shreg_d = shifted;
                            cnt_d   = cnt_q + CW'(1);
                        end
                    end else begin
                        frame_err_d = 1'b1;
                        state_d     = IDLE;
                        cnt_d       = '0;
                        shreg_d     = '0;
                    end
                end
                default: state_d = IDLE;
            endcase
            // A completed word can replace one being accepted this edge, but never an unaccepted one.
            if (word_done) begin
                if (valid_q && !bus.ready_i) begin
                    overrun_d = 1'b1;
                end else begin
                    data_d  = word;
                    valid_d = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            shreg_q     <= '0;
            data_q      <= '0;
            valid_q     <= 1'b0;
            frame_err_q <= 1'b0;
            overrun_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            shreg_q     <= shreg_d;
            data_q      <= data_d;
            valid_q     <= valid_d;
            frame_err_q <= frame_err_d;
            overrun_q   <= overrun_d;
        end
    end

`ifdef SIPO_RX_PARITY_CHECK_EN
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) parity_err_q <= 1'b0;
        else          parity_err_q <= parity_err_d;
    end
    assign bus.parity_err_o = parity_err_q;
`else
    assign bus.parity_err_o = 1'b0;
`endif

    assign bus.data_o      = data_q;
    assign bus.valid_o     = valid_q;
    assign bus.busy_o      = (state_q == SHIFT);
    assign bus.frame_err_o = frame_err_q;
    assign bus.overrun_o   = overrun_q;
endmodule

// File: tb/tb_sipo_rx.sv
// Bench for sipo_rx: directed vector table, reset/clear corner sequences, and random traffic
// checked against a frame-level model for both bit orders.
module tb_sipo_rx;
    localparam int W = 4;
`ifdef SIPO_RX_PARITY_CHECK_EN
    localparam int PAR = 1;
`else
    localparam int PAR = 0;
`endif
    localparam int L = W + PAR;

    logic clk = 1'b0;
    logic rst_n, clear, ser_valid, ser_data, ready;
    int   n_cmp = 0;
    int   n_fail = 0;

    always #5 clk = ~clk;

    sipo_rx_if #(.WIDTH(W)) if_m ();
    sipo_rx_if #(.WIDTH(W)) if_l ();

    assign if_m.ser_valid_i = ser_valid;
    assign if_m.ser_data_i  = ser_data;
    assign if_m.ready_i     = ready;
    assign if_l.ser_valid_i = ser_valid;
    assign if_l.ser_data_i  = ser_data;
    assign if_l.ready_i     = ready;

    sipo_rx #(.WIDTH(W), .MSB_FIRST(1'b1)) dut_m (
        .clk_i(clk), .rst_n_i(rst_n), .clear_i(clear), .bus(if_m.slave));
    sipo_rx #(.WIDTH(W), .MSB_FIRST(1'b0)) dut_l (
        .clk_i(clk), .rst_n_i(rst_n), .clear_i(clear), .bus(if_l.slave));

    // Frame-level reference: collect bits in a queue, build the word arithmetically when L arrive.
    bit           mbits[$];
    logic         m_valid, m_fe, m_ov, m_pe;
    logic [W-1:0] m_dmsb, m_dlsb;

    function automatic void model_reset();
        mbits.delete();
        m_valid = 1'b0; m_fe = 1'b0; m_ov = 1'b0; m_pe = 1'b0;
        m_dmsb = '0; m_dlsb = '0;
    endfunction

    function automatic void model_step();
        logic old_valid;
        int   ones;
        old_valid = m_valid;
        m_fe = 1'b0; m_ov = 1'b0; m_pe = 1'b0;
        if (!rst_n) begin
            model_reset();
        end else if (clear) begin
            mbits.delete();
            m_valid = 1'b0;
        end else begin
            if (m_valid && ready) m_valid = 1'b0;
            if (ser_valid) begin
                mbits.push_back(ser_data);
                if (mbits.size() == L) begin
                    ones = 0;
                    for (int i = 0; i < L; i++) ones += int'(mbits[i]);
                    if (PAR == 1 && (ones % 2) != 0) begin
                        m_pe = 1'b1;
                    end else if (old_valid && !ready) begin
                        m_ov = 1'b1;
                    end else begin
                        m_valid = 1'b1;
                        for (int i = 0; i < W; i++) begin
                            m_dmsb[W-1-i] = mbits[i];
                            m_dlsb[i]     = mbits[i];
                        end
                    end
                    mbits.delete();
                end
            end else if (mbits.size() != 0) begin
                m_fe = 1'b1;
                mbits.delete();
            end
        end
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic chk_model(input string tag);
        chk({tag, " m.valid"}, 32'(if_m.valid_o), 32'(m_valid));
        chk({tag, " m.data"},  32'(if_m.data_o),  32'(m_dmsb));
        chk({tag, " m.busy"},  32'(if_m.busy_o),  32'(mbits.size() != 0));
        chk({tag, " m.fe"},    32'(if_m.frame_err_o), 32'(m_fe));
        chk({tag, " m.ov"},    32'(if_m.overrun_o),   32'(m_ov));
        chk({tag, " m.pe"},    32'(if_m.parity_err_o), 32'(m_pe));
        chk({tag, " l.valid"}, 32'(if_l.valid_o), 32'(m_valid));
        chk({tag, " l.data"},  32'(if_l.data_o),  32'(m_dlsb));
        chk({tag, " l.busy"},  32'(if_l.busy_o),  32'(mbits.size() != 0));
    endtask

    task automatic step(input logic sv, input logic sd, input logic rdy, input logic clr,
                        input string tag);
        ser_valid = sv; ser_data = sd; ready = rdy; clear = clr;
        @(posedge clk);
        model_step();
        #1;
        chk_model(tag);
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, " valid"}, 32'({if_m.valid_o, if_l.valid_o}), 32'(0));
        chk({tag, " data"},  32'({if_m.data_o, if_l.data_o}), 32'(0));
        chk({tag, " busy"},  32'({if_m.busy_o, if_l.busy_o}), 32'(0));
        chk({tag, " pulses"}, 32'({if_m.frame_err_o, if_m.overrun_o, if_m.parity_err_o}), 32'(0));
    endtask

    typedef struct {
        logic       sv, sd, rdy, clr;
        logic       e_valid;
        logic [3:0] e_data;
        logic       e_busy, e_fe, e_ov;
    } vec_t;
    vec_t tbl[$];

    function automatic void add(input logic sv, sd, rdy, clr, ev, input logic [3:0] ed,
                                input logic eb, efe, eov);
        vec_t v;
        v.sv = sv; v.sd = sd; v.rdy = rdy; v.clr = clr;
        v.e_valid = ev; v.e_data = ed; v.e_busy = eb; v.e_fe = efe; v.e_ov = eov;
        tbl.push_back(v);
    endfunction

    initial begin
        rst_n = 1'b0; clear = 1'b0; ser_valid = 1'b0; ser_data = 1'b0; ready = 1'b0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        chk_all_zero("reset");
        rst_n = 1'b1;

`ifndef SIPO_RX_PARITY_CHECK_EN
        // frame 0110 with ready low, then hold and accept
        add(1,0,0,0, 0,4'h0,1,0,0); add(1,1,0,0, 0,4'h0,1,0,0);
        add(1,1,0,0, 0,4'h0,1,0,0); add(1,0,0,0, 1,4'h6,0,0,0);
        for (int i = 0; i < 5; i++) add(0,0,0,0, 1,4'h6,0,0,0);
        add(0,0,1,0, 0,4'h6,0,0,0);
        // A then 3 back-to-back, ready low: overrun on 3
        add(1,1,0,0, 0,4'h6,1,0,0); add(1,0,0,0, 0,4'h6,1,0,0);
        add(1,1,0,0, 0,4'h6,1,0,0); add(1,0,0,0, 1,4'hA,0,0,0);
        add(1,0,0,0, 1,4'hA,1,0,0); add(1,0,0,0, 1,4'hA,1,0,0);
        add(1,1,0,0, 1,4'hA,1,0,0); add(1,1,0,0, 1,4'hA,0,0,1);
        add(0,0,1,0, 0,4'hA,0,0,0);
        // same with ready high
        add(1,1,1,0, 0,4'hA,1,0,0); add(1,0,1,0, 0,4'hA,1,0,0);
        add(1,1,1,0, 0,4'hA,1,0,0); add(1,0,1,0, 1,4'hA,0,0,0);
        add(1,0,1,0, 0,4'hA,1,0,0); add(1,0,1,0, 0,4'hA,1,0,0);
        add(1,1,1,0, 0,4'hA,1,0,0); add(1,1,1,0, 1,4'h3,0,0,0);
        add(0,0,1,0, 0,4'h3,0,0,0);
        // truncated frame, then 1001
        add(1,1,0,0, 0,4'h3,1,0,0); add(1,0,0,0, 0,4'h3,1,0,0);
        add(0,0,0,0, 0,4'h3,0,1,0);
        add(1,1,0,0, 0,4'h3,1,0,0); add(1,0,0,0, 0,4'h3,1,0,0);
        add(1,0,0,0, 0,4'h3,1,0,0); add(1,1,0,0, 1,4'h9,0,0,0);
        add(0,0,1,0, 0,4'h9,0,0,0);
        // clear after two bits (ser_valid ignored), then 0101, then clear drops pending word
        add(1,0,0,0, 0,4'h9,1,0,0); add(1,1,0,0, 0,4'h9,1,0,0);
        add(1,1,0,1, 0,4'h9,0,0,0);
        add(1,0,0,0, 0,4'h9,1,0,0); add(1,1,0,0, 0,4'h9,1,0,0);
        add(1,0,0,0, 0,4'h9,1,0,0); add(1,1,0,0, 1,4'h5,0,0,0);
        add(0,0,0,1, 0,4'h5,0,0,0);

        for (int i = 0; i < tbl.size(); i++) begin
            step(tbl[i].sv, tbl[i].sd, tbl[i].rdy, tbl[i].clr, $sformatf("tbl%0d", i));
            chk($sformatf("tbl%0d valid", i), 32'(if_m.valid_o), 32'(tbl[i].e_valid));
            chk($sformatf("tbl%0d data", i),  32'(if_m.data_o),  32'(tbl[i].e_data));
            chk($sformatf("tbl%0d busy", i),  32'(if_m.busy_o),  32'(tbl[i].e_busy));
            chk($sformatf("tbl%0d fe", i),    32'(if_m.frame_err_o), 32'(tbl[i].e_fe));
            chk($sformatf("tbl%0d ov", i),    32'(if_m.overrun_o),   32'(tbl[i].e_ov));
            if (i == 3) chk("lsb_first 0110", 32'(if_l.data_o), 32'(4'h6));
        end
`else
        // 0110 with correct even parity accepted; with wrong parity rejected
        step(1,0,0,0,"p0"); step(1,1,0,0,"p1"); step(1,1,0,0,"p2"); step(1,0,0,0,"p3");
        step(1,0,0,0,"p4");
        chk("par_ok valid", 32'(if_m.valid_o), 32'(1));
        chk("par_ok data",  32'(if_m.data_o),  32'(4'h6));
        chk("par_ok lsb",   32'(if_l.data_o),  32'(4'h6));
        step(0,0,1,0,"p5");
        step(1,0,0,0,"q0"); step(1,1,0,0,"q1"); step(1,1,0,0,"q2"); step(1,0,0,0,"q3");
        step(1,1,0,0,"q4");
        chk("par_bad pulse", 32'(if_m.parity_err_o), 32'(1));
        chk("par_bad valid", 32'(if_m.valid_o), 32'(0));
        step(0,0,0,0,"q5");
        chk("par_bad pulse width", 32'(if_m.parity_err_o), 32'(0));
`endif

        // asynchronous reset mid-frame: outputs drop without waiting for a clock
        step(1,1,0,0,"r0"); step(1,0,0,0,"r1"); step(1,1,0,0,"r2");
        #3;
        rst_n = 1'b0;
        #1;
        chk_all_zero("async_rst");
        model_reset();
        step(1,1,0,0,"r_hold");
        rst_n = 1'b1;
        step(0,0,0,0,"r_idle");

        for (int c = 0; c < 3000; c++) begin
            step(($urandom % 8) != 0, $urandom % 2, $urandom % 2, ($urandom % 50) == 0,
                 $sformatf("rnd%0d", c));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule

// File: doc/sipo_rx.md
Name: sipo_rx

Overview:
- 4-bit-class serial-in parallel-out deserializer: the receive end of the piso serial link.
- Samples a serial bit stream qualified by a valid strobe; this strobe connects directly to the transmitter's busy_o.
- Assembles WIDTH-bit words and presents them on a valid/ready parallel output.
- Detects truncated frames and output overrun.

Parameters:
- WIDTH, 4, bits per word; legal range 2..32.
- MSB_FIRST, 1, 1 = first received bit lands in data_o[WIDTH-1]; 0 = first received bit lands in data_o[0].

Ports:
- clk_i  input  1  clock; all logic on rising edge.
- rst_n_i  input  1  asynchronous active-low reset.
- clear_i  input  1  synchronous abort; highest priority after reset.
- ser_valid_i  input  1  qualifies ser_data_i this cycle (driven from transmitter busy_o).
- ser_data_i  input  1  serial data bit.
- ready_i  input  1  downstream accepts data_o when valid_o=1.
- data_o  output  WIDTH  assembled word; stable while valid_o=1.
- valid_o  output  1  word available.
- busy_o  output  1  frame in progress (state SHIFT).
- frame_err_o  output  1  one-cycle pulse: frame truncated.
- overrun_o  output  1  one-cycle pulse: completed word dropped.
- parity_err_o  output  1  one-cycle pulse: parity mismatch (see Optional Feature).

Behaviour:
- Reset (async, rst_n_i=0):
  - state=IDLE, bit counter=0, shift register=0.
  - data_o=0, valid_o=0, busy_o=0, all error pulses=0.
  - Reset mid-frame discards the partial word; no error pulse is generated.
- Frame length: L = WIDTH (WIDTH+1 with PARITY_CHECK_EN).
- Bit counter is $clog2(L+1) bits.
- FSM, 2 states:
  - IDLE:
    - If ser_valid_i=1, capture bit 0, counter=1, go to SHIFT.
    - If L is reached the same edge (not possible for WIDTH>=2), no special case is needed.
  - SHIFT, ser_valid_i=1:
    - Capture the bit; counter+1.
    - When the captured bit is bit L-1, the frame is complete: go to IDLE, counter=0.
  - SHIFT, ser_valid_i=0 before L bits:
    - frame_err_o=1 for one cycle; partial word discarded; go to IDLE.
- Bit placement:
  - MSB_FIRST=1: shift left, new bit into LSB.
  - MSB_FIRST=0: shift right, new bit into MSB.
  - After WIDTH bits, word bit order equals transmitted parallel order.
- Latency: valid_o and data_o update on the same rising edge that samples the last data bit, so they are visible the cycle after the last bit is presented.
- Back-to-back frames: ser_valid_i may stay high across frames. The bit after a completed frame is bit 0 of the next frame, with no gap cycle.
- Output handshake:
  - Transfer occurs at any edge with valid_o=1 and ready_i=1.
  - After a transfer, valid_o clears, unless a new word completes at the same edge; then valid_o stays 1 and data_o takes the new word.
- Overrun: a word completes while valid_o=1 and ready_i=0.
  - New word dropped; data_o and valid_o unchanged.
  - overrun_o=1 for one cycle.
- busy_o = (state==SHIFT).
- clear_i=1 at an edge:
  - state=IDLE, counter=0, valid_o=0.
  - No error pulses that cycle.
  - ser_valid_i that cycle is ignored.
- Simultaneous frame_err/overrun: not possible in the same cycle. Frame error and parity error are mutually exclusive per frame.

Optional Feature:
- Macro: SIPO_RX_PARITY_CHECK_EN.
- Defined:
  - Each frame carries WIDTH data bits followed by one even-parity bit (XOR of data bits and parity = 0).
  - On mismatch: word discarded, valid_o unchanged, parity_err_o pulses one cycle; no overrun check for that word.
- Not defined:
  - Frame is WIDTH bits.
  - parity_err_o is tied to 0.

Test Plan:
- Reset then single frame:
  - Stimulus: WIDTH=4, MSB_FIRST=1, ser_valid_i=1 for 4 cycles with bits 0,1,1,0; ready_i=0.
  - Response: valid_o=1 and data_o=4'h6 from the cycle after bit 4; busy_o=1 during bits 2-4.
- Handshake hold:
  - Stimulus: with 4'h6 pending, hold ready_i=0 for 5 cycles, then ready_i=1 for one cycle.
  - Response: data_o=4'h6 stable throughout; valid_o=0 after the accepting edge.
- Back-to-back with overrun:
  - Stimulus: frames 4'hA then 4'h3 contiguous, ready_i=0.
  - Response: data_o=4'hA held; overrun_o one-cycle pulse when 4'h3 completes.
  - Repeat with ready_i=1: 4'hA then 4'h3 each valid one cycle, no overrun.
- Truncated frame:
  - Stimulus: ser_valid_i high for 2 bits, then low.
  - Response: frame_err_o pulse the cycle after valid drops, valid_o stays 0.
  - A following full frame 4'h9 is received correctly.
- Reset/clear mid-frame:
  - Stimulus: drop rst_n_i asynchronously after 3 bits.
  - Response: all outputs 0 immediately.
  - Repeat with clear_i after 2 bits: no error pulse; next frame 4'h5 is received correctly.
- LSB-first and parity:
  - Stimulus: MSB_FIRST=0, bits 0,1,1,0.
  - Response: data_o=4'h6.
  - With SIPO_RX_PARITY_CHECK_EN: 4'h6 with parity 0 accepted; 4'h6 with parity 1 gives a parity_err_o pulse and no valid_o.
